// File: rtl/ser2par_fifo.sv
// ser2par_fifo
//
// Serial-to-parallel converter feeding a small output FIFO with a
// valid/ready handshake. One serial bit is accepted on every clk edge where
// wr_n is low. A word is pushed into the FIFO on the edge that accepts its
// last bit. Dropping wr_n high in the middle of a word discards the partial
// word and pulses abort. Words that arrive while the FIFO is full and not
// being popped are dropped, and the sticky ovf flag is set.
//
// Parameters:
//   DATA_W     word width, 2..32
//   MSB_FIRST  1: first serial bit lands in dout[DATA_W-1]; 0: in dout[0]
//   DEPTH      FIFO depth in words, power of two, >= 2
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       asynchronous active-high reset
//   wr_n      active-low bit enable
//   din       serial data bit
//   dout_rdy  consumer ready
//   dout_vld  FIFO head valid
//   dout      FIFO head word, zero when dout_vld=0
//   level     words held in the FIFO (0..DEPTH)
//   abort     one-cycle pulse when a partial word is discarded
//   ovf       sticky overflow flag
//   ovf_clr   clears ovf (a same-cycle overflow takes priority)

module ser2par_fifo #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_n,
  input  logic                     din,
  input  logic                     dout_rdy,
  output logic                     dout_vld,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     abort,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int CW = $clog2(DATA_W);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  // Only DATA_W-1 bits ever wait in the shift register; the final bit of a
  // word comes straight from din on the completion edge.
  logic [DATA_W-2:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [DATA_W-1:0] word;
  logic              push, pop, full, accept, drop;

  // Shift register contents with the current din appended in the
  // configured bit order.
  always_comb begin
    if (MSB_FIRST) word = {sh_q, din};
    else           word = {din, sh_q};
  end

  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    if (!wr_n) begin
      if (cnt_q == CNT_LAST) begin
        sh_d  = '0;
        cnt_d = '0;
      end else begin
        if (MSB_FIRST) sh_d = word[DATA_W-2:0];
        else           sh_d = word[DATA_W-1:1];
        cnt_d = cnt_q + CW'(1);
      end
    end else if (cnt_q != '0) begin
      sh_d    = '0;
      cnt_d   = '0;
      abort_d = 1'b1;
    end
  end

  assign push     = !wr_n && (cnt_q == CNT_LAST);
  assign dout_vld = (level_q != '0);
  assign pop      = dout_vld && dout_rdy;
  assign full     = (level_q == LW'(DEPTH));
  // A pop on the same edge frees the slot, so a push into a full FIFO is
  // still accepted in that case.
  assign accept   = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[wptr_q] = word;
  end

  always_comb begin
    wptr_d  = accept ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop    ? rptr_q + PW'(1) : rptr_q;
    level_d = level_q;
    if (accept && !pop)      level_d = level_q + LW'(1);
    else if (!accept && pop) level_d = level_q - LW'(1);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      mem_q   <= mem_d;
    end
  end

  assign dout  = dout_vld ? mem_q[rptr_q] : '0;
  assign level = level_q;
  assign abort = abort_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_ser2par_fifo.sv
module tb_ser2par_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_n = 1'b1;
  logic       din = 1'b0;
  logic       dout_rdy = 1'b0;
  logic       ovf_clr = 1'b0;

  logic       m_vld, m_abort, m_ovf;
  logic [7:0] m_dout;
  logic [2:0] m_level;
  logic       l_vld, l_abort, l_ovf;
  logic [7:0] l_dout;
  logic [2:0] l_level;

  int n_checks = 0;
  int n_fail = 0;
  int m_abort_cnt = 0;
  int l_abort_cnt = 0;

  always #5 clk = ~clk;

  ser2par_fifo #(.DATA_W(8), .MSB_FIRST(1'b1), .DEPTH(4)) u_msb (
    .clk(clk), .rst(rst), .wr_n(wr_n), .din(din), .dout_rdy(dout_rdy),
    .dout_vld(m_vld), .dout(m_dout), .level(m_level), .abort(m_abort),
    .ovf(m_ovf), .ovf_clr(ovf_clr)
  );

  ser2par_fifo #(.DATA_W(8), .MSB_FIRST(1'b0), .DEPTH(4)) u_lsb (
    .clk(clk), .rst(rst), .wr_n(wr_n), .din(din), .dout_rdy(dout_rdy),
    .dout_vld(l_vld), .dout(l_dout), .level(l_level), .abort(l_abort),
    .ovf(l_ovf), .ovf_clr(ovf_clr)
  );

  always @(negedge clk) begin
    if (m_abort) m_abort_cnt++;
    if (l_abort) l_abort_cnt++;
  end

  task automatic do_reset();
    rst = 1'b1; wr_n = 1'b1; din = 1'b0; dout_rdy = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives the 8 bits of w, MSB first in time; dout_rdy/ovf_clr take the
  // given values on the completion bit only.
  task automatic send_word(input logic [7:0] w, input logic last_rdy, input logic last_clr);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_n = 1'b0;
      din  = w[7-i];
      if (i == 7) begin
        dout_rdy = last_rdy;
        ovf_clr  = last_clr;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({m_vld, m_dout, m_level, m_abort, m_ovf} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got vld=%b dout=%h level=%0d abort=%b ovf=%b want all 0",
               m_vld, m_dout, m_level, m_abort, m_ovf);
    end
    do_reset();
  endtask

  task automatic test_msb_first();
    do_reset();
    dout_rdy = 1'b1;
    send_word(8'hB2, 1'b1, 1'b0);
    @(negedge clk);
    wr_n = 1'b1;
    n_checks++;
    if (m_vld !== 1'b1 || m_dout !== 8'hB2) begin
      n_fail++;
      $display("FAIL msb_word got vld=%b dout=%h want vld=1 dout=b2", m_vld, m_dout);
    end
    n_checks++;
    if (m_level !== 3'd1) begin
      n_fail++;
      $display("FAIL msb_level got %0d want 1", m_level);
    end
    @(negedge clk);
    n_checks++;
    if (m_level !== 3'd0 || m_vld !== 1'b0 || m_dout !== 8'h00) begin
      n_fail++;
      $display("FAIL msb_after_pop got level=%0d vld=%b dout=%h want 0 0 00", m_level, m_vld, m_dout);
    end
  endtask

  task automatic test_lsb_first();
    int a0;
    do_reset();
    a0 = l_abort_cnt;
    dout_rdy = 1'b1;
    send_word(8'hB2, 1'b1, 1'b0);
    @(negedge clk);
    wr_n = 1'b1;
    n_checks++;
    if (l_vld !== 1'b1 || l_dout !== 8'h4D) begin
      n_fail++;
      $display("FAIL lsb_word got vld=%b dout=%h want vld=1 dout=4d", l_vld, l_dout);
    end
    @(negedge clk);
    n_checks++;
    if (l_abort_cnt - a0 !== 0) begin
      n_fail++;
      $display("FAIL lsb_no_abort got %0d pulses want 0", l_abort_cnt - a0);
    end
  endtask

  task automatic test_abort();
    int a0;
    do_reset();
    a0 = m_abort_cnt;
    dout_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_n = 1'b0;
      din  = 1'b1;
    end
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_abort !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pulse got %b want 1", m_abort);
    end
    n_checks++;
    if (m_vld !== 1'b0 || m_level !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_no_fragment got vld=%b level=%0d want 0 0", m_vld, m_level);
    end
    // stay idle one cycle here; the abort pulse should fall without a repeat
    send_word(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    wr_n = 1'b1;
    n_checks++;
    if (m_vld !== 1'b1 || m_dout !== 8'hA5 || m_level !== 3'd1) begin
      n_fail++;
      $display("FAIL abort_word got vld=%b dout=%h level=%0d want 1 a5 1", m_vld, m_dout, m_level);
    end
    @(negedge clk);
    n_checks++;
    if (m_level !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_one_word got level=%0d want 0", m_level);
    end
    n_checks++;
    if (m_abort_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL abort_count got %0d pulses want 1", m_abort_cnt - a0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b0, 1'b0);
    @(negedge clk);
    wr_n = 1'b1;
    n_checks++;
    if (m_level !== 3'd4 || m_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full got level=%0d ovf=%b want 4 1", m_level, m_ovf);
    end
    n_checks++;
    if (m_vld !== 1'b1 || m_dout !== 8'h01) begin
      n_fail++;
      $display("FAIL ovf_head got vld=%b dout=%h want 1 01", m_vld, m_dout);
    end
    dout_rdy = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_dout !== 8'(i) || m_level !== 3'(5 - i)) begin
        n_fail++;
        $display("FAIL ovf_pop%0d got dout=%h level=%0d want %h %0d", i, m_dout, m_level, 8'(i), 5 - i);
      end
    end
    @(negedge clk);
    dout_rdy = 1'b0;
    n_checks++;
    if (m_level !== 3'd0 || m_vld !== 1'b0 || m_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drained got level=%0d vld=%b ovf=%b want 0 0 1", m_level, m_vld, m_ovf);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_checks++;
    if (m_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear got %b want 0", m_ovf);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b0);
    send_word(8'h55, 1'b1, 1'b0);
    @(negedge clk);
    wr_n = 1'b1;
    dout_rdy = 1'b0;
    n_checks++;
    if (m_level !== 3'd4 || m_ovf !== 1'b0 || m_dout !== 8'h22) begin
      n_fail++;
      $display("FAIL full_pushpop got level=%0d ovf=%b dout=%h want 4 0 22", m_level, m_ovf, m_dout);
    end
    dout_rdy = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_dout !== 8'(i * 17)) begin
        n_fail++;
        $display("FAIL full_drain%0d got %h want %h", i, m_dout, 8'(i * 17));
      end
    end
    @(negedge clk);
    dout_rdy = 1'b0;
    // refill, then drop a word while ovf_clr is asserted on the same edge
    for (int w = 1; w <= 4; w++) send_word(8'(w), 1'b0, 1'b0);
    send_word(8'h99, 1'b0, 1'b1);
    @(negedge clk);
    wr_n = 1'b1;
    ovf_clr = 1'b0;
    n_checks++;
    if (m_ovf !== 1'b1 || m_level !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_set_wins got ovf=%b level=%0d want 1 4", m_ovf, m_level);
    end
  endtask

  task automatic test_async_reset();
    int a0;
    do_reset();
    for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_n = 1'b0;
      din  = 1'b1;
    end
    @(posedge clk);
    #2;
    rst  = 1'b1;
    wr_n = 1'b1;
    #1;
    n_checks++;
    if ({m_vld, m_dout, m_level, m_abort, m_ovf} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset got vld=%b dout=%h level=%0d abort=%b ovf=%b want all 0",
               m_vld, m_dout, m_level, m_abort, m_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    a0 = m_abort_cnt;
    dout_rdy = 1'b1;
    send_word(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    wr_n = 1'b1;
    n_checks++;
    if (m_vld !== 1'b1 || m_dout !== 8'h3C) begin
      n_fail++;
      $display("FAIL post_reset_word got vld=%b dout=%h want 1 3c", m_vld, m_dout);
    end
    n_checks++;
    if (m_abort_cnt - a0 !== 0) begin
      n_fail++;
      $display("FAIL post_reset_abort got %0d pulses want 0", m_abort_cnt - a0);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_abort();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
